search_controller: RTL and testbench

Sequencing controller that sits directly upstream of the word-search engine. On a start request it walks SRAM addresses from 0, drives the per-word character index into the engine, and tracks where each word begins. It qualifies the engine's `match`/`ETX`/`sp` flags and reports completion, hit/miss, and the start address of the matched word. The SRAM is asynchronous-read: `data` is valid in the same cycle as `addr`.

---
 rtl/search_controller.sv | 154 +++++++++++++++
 tb/tb_search_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/search_controller.sv
// search_controller: sequencer sitting upstream of the word-search engine.
// On a start request it walks SRAM addresses from 0 and drives the per-word
// character index into the engine. It tracks where each word begins, qualifies
// the engine flags, and reports done / hit / hit_addr.
//
// Optional feature macro: SEARCH_CTRL_WORDCNT_EN adds the wcount port and a
// saturating 16-bit count of non-terminating spaces seen during a scan.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   new_search  in   start/restart search (the engine's `new` pulse;
//                    `new` itself is a reserved word)
//   match       in   engine word-equals-search flag for the current data
//   ETX         in   engine end-of-text flag
//   sp          in   engine space flag
//   addr        out  SRAM read address (asynchronous-read SRAM)
//   CharCount   out  character index within the current word, to engine
//   busy        out  scan in progress
//   done        out  search finished, held until the next new_search
//   hit         out  qualified match found (valid with done)
//   hit_addr    out  address of the first character of the matched word
//   wcount      out  (SEARCH_CTRL_WORDCNT_EN only) word-separator count
module search_controller #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MAX_ADDR = 2**ADDR_W - 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              new_search,
  input  logic              match,
  input  logic              ETX,
  input  logic              sp,
  output logic [ADDR_W-1:0] addr,
  output logic [2:0]        CharCount,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [ADDR_W-1:0] hit_addr
`ifdef SEARCH_CTRL_WORDCNT_EN
  ,
  output logic [15:0]       wcount
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MAX_ADDR);
  localparam logic [2:0]        CC_MAX     = 3'd6;
  localparam logic [2:0]        CC_HIT_MAX = 3'd5;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] word_start, word_start_nxt;
  logic [ADDR_W-1:0] addr_nxt, hit_addr_nxt;
  logic [2:0]        cc_nxt;
  logic              hit_nxt, busy_nxt, done_nxt;

  // A match only counts while the word still fits the engine's 5-char compare.
  logic scan_hit, scan_end;
  assign scan_hit = match && (CharCount <= CC_HIT_MAX);
  assign scan_end = scan_hit || ETX || (addr == LAST_ADDR);

`ifdef SEARCH_CTRL_WORDCNT_EN
  logic [15:0] wcount_nxt;
`endif

  // State register plus registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      CharCount  <= '0;
      word_start <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit        <= 1'b0;
      hit_addr   <= '0;
`ifdef SEARCH_CTRL_WORDCNT_EN
      wcount     <= '0;
`endif
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      CharCount  <= cc_nxt;
      word_start <= word_start_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      hit        <= hit_nxt;
      hit_addr   <= hit_addr_nxt;
`ifdef SEARCH_CTRL_WORDCNT_EN
      wcount     <= wcount_nxt;
`endif
    end
  end

  // Next-state: new_search wins in every state; SCAN ends on any terminator.
  always_comb begin
    state_nxt = state;
    if (new_search) begin
      state_nxt = SCAN;
    end else begin
      case (state)
        SCAN:    if (scan_end) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Next values of the registered outputs and scan datapath.
  always_comb begin
    addr_nxt       = addr;
    cc_nxt         = CharCount;
    word_start_nxt = word_start;
    hit_nxt        = hit;
    hit_addr_nxt   = hit_addr;
    busy_nxt       = (state_nxt == SCAN);
    done_nxt       = (state_nxt == DONE);
    if (new_search) begin
      addr_nxt       = '0;
      cc_nxt         = '0;
      word_start_nxt = '0;
      hit_nxt        = 1'b0;
      hit_addr_nxt   = '0;
    end else if (state == SCAN) begin
      if (scan_hit) begin
        hit_nxt      = 1'b1;
        hit_addr_nxt = word_start;
      end else if (ETX || (addr == LAST_ADDR)) begin
        hit_nxt = 1'b0;
      end else begin
        addr_nxt = addr + ADDR_W'(1);
        if (sp) begin
          cc_nxt         = '0;
          word_start_nxt = addr + ADDR_W'(1);
        end else if (CharCount < CC_MAX) begin
          cc_nxt = CharCount + 3'd1;
        end
      end
    end
  end

`ifdef SEARCH_CTRL_WORDCNT_EN
  // Counts spaces that advance the scan; a terminating cycle never counts.
  always_comb begin
    wcount_nxt = wcount;
    if (new_search) begin
      wcount_nxt = '0;
    end else if ((state == SCAN) && !scan_end && sp && (wcount != 16'hFFFF)) begin
      wcount_nxt = wcount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_search_controller.sv
// Self-checking bench for search_controller. The engine is modelled by
// per-address flag tables driven combinationally from addr; expected results
// come from a plain walk over those tables.
module tb_search_controller;

  localparam int TB_ADDR_W = 5;
  localparam int TB_MAX    = 15;
  localparam int DEPTH     = 32;
  localparam int BUDGET    = 40;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 new_search = 1'b0;
  logic                 match, ETX, sp;
  logic [TB_ADDR_W-1:0] addr;
  logic [2:0]           CharCount;
  logic                 busy, done, hit;
  logic [TB_ADDR_W-1:0] hit_addr;
`ifdef SEARCH_CTRL_WORDCNT_EN
  logic [15:0]          wcount;
`endif

  bit mflag [DEPTH];
  bit eflag [DEPTH];
  bit sflag [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  assign match = mflag[addr];
  assign ETX   = eflag[addr];
  assign sp    = sflag[addr];

  search_controller #(.ADDR_W(TB_ADDR_W), .MAX_ADDR(TB_MAX)) dut (
    .clock      (clock),
    .reset      (reset),
    .new_search (new_search),
    .match      (match),
    .ETX        (ETX),
    .sp         (sp),
    .addr       (addr),
    .CharCount  (CharCount),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .hit_addr   (hit_addr)
`ifdef SEARCH_CTRL_WORDCNT_EN
    ,
    .wcount     (wcount)
`endif
  );

  // Builds engine flags from a text: sp on ' ', ETX on the appended 03h, and
  // match on a delimiter when the word's first 5 chars equal the search word.
  task automatic load_text(input string s, input string srch);
    string w, w5;
    byte   c;
    for (int i = 0; i < DEPTH; i++) begin
      mflag[i] = 1'b0; eflag[i] = 1'b0; sflag[i] = 1'b0;
    end
    w = "";
    for (int i = 0; i <= s.len(); i++) begin
      c = (i == s.len()) ? 8'h03 : s[i];
      sflag[i] = (c == 8'h20);
      eflag[i] = (c == 8'h03);
      if (c == 8'h20 || c == 8'h03) begin
        w5 = (w.len() > 5) ? w.substr(0, 4) : w;
        mflag[i] = (w.len() > 0) && (w5 == srch);
        w = "";
      end else begin
        w = $sformatf("%s%c", w, c);
      end
    end
  endtask

  // Reference: walk addresses from 0 applying the scan rules directly.
  task automatic model_scan(output int k, output bit h, output int ha,
                            output int cc, output int wc);
    int ws;
    cc = 0; ws = 0; wc = 0; h = 1'b0; ha = 0;
    for (k = 0; k < DEPTH; k++) begin
      if (mflag[k] && cc <= 5) begin h = 1'b1; ha = ws; return; end
      if (eflag[k] || k == TB_MAX) return;
      if (sflag[k]) begin wc++; cc = 0; ws = k + 1; end
      else if (cc < 6) cc++;
    end
  endtask

  // Pulses new_search and waits for done; counts cycles whose addr/busy
  // do not follow one-address-per-cycle progress.
  task automatic start_and_wait(output int done_cyc, output int bad_steps);
    @(negedge clock); new_search = 1'b1;
    @(negedge clock); new_search = 1'b0;
    done_cyc = -1; bad_steps = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      if (done) begin done_cyc = n; break; end
      if (busy !== 1'b1 || addr !== TB_ADDR_W'(n - 1)) bad_steps++;
      if (n < BUDGET) @(negedge clock);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({addr, CharCount, busy, done, hit, hit_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got addr=%0d cc=%0d busy=%b done=%b hit=%b hit_addr=%0d, want all 0",
               addr, CharCount, busy, done, hit, hit_addr);
    end
`ifdef SEARCH_CTRL_WORDCNT_EN
    n_cmp++;
    if (wcount !== 16'd0) begin
      n_err++; $display("FAIL reset_wcount: got %0d want 0", wcount);
    end
`endif
    reset = 1'b0;
  endtask

  // Runs one scan over the loaded flag tables and checks against the model.
  task automatic test_scan(input string name);
    int k, ha, cc, wc, dc, bad;
    bit h;
    model_scan(k, h, ha, cc, wc);
    start_and_wait(dc, bad);
    n_cmp++;
    if (dc !== k + 2) begin
      n_err++; $display("FAIL %s done_cycle: got %0d want %0d", name, dc, k + 2);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++; $display("FAIL %s scan_progress: got %0d bad cycles want 0", name, bad);
    end
    n_cmp++;
    if ({busy, hit, hit_addr, addr, CharCount} !==
        {1'b0, h, TB_ADDR_W'(ha), TB_ADDR_W'(k), 3'(cc)}) begin
      n_err++;
      $display("FAIL %s result: got busy=%b hit=%b hit_addr=%0d addr=%0d cc=%0d want busy=0 hit=%b hit_addr=%0d addr=%0d cc=%0d",
               name, busy, hit, hit_addr, addr, CharCount, h, ha, k, cc);
    end
`ifdef SEARCH_CTRL_WORDCNT_EN
    n_cmp++;
    if (wcount !== 16'(wc)) begin
      n_err++; $display("FAIL %s wcount: got %0d want %0d", name, wcount, wc);
    end
`endif
    @(negedge clock);
    n_cmp++;
    if ({done, busy, addr} !== {1'b1, 1'b0, TB_ADDR_W'(k)}) begin
      n_err++;
      $display("FAIL %s hold: got done=%b busy=%b addr=%0d want done=1 busy=0 addr=%0d",
               name, done, busy, addr, k);
    end
  endtask

  task automatic test_directed();
    load_text("the cat sat", "cat");  test_scan("cat_hit");
    load_text("abcdefg dog", "abcde"); test_scan("long_word_reject");
    load_text("dog", "cat");          test_scan("etx_miss");
    load_text("a  cat", "cat");       test_scan("double_space");
  endtask

  task automatic test_runaway();
    for (int i = 0; i < DEPTH; i++) begin
      mflag[i] = 1'b0; eflag[i] = 1'b0; sflag[i] = 1'b0;
    end
    test_scan("runaway");
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mflag[i] = ($urandom_range(0, 9) == 0);
        eflag[i] = ($urandom_range(0, 19) == 0);
        sflag[i] = ($urandom_range(0, 3) == 0);
      end
      test_scan($sformatf("random%0d", t));
    end
  endtask

  // new_search mid-scan restarts from 0 with no intervening done.
  task automatic test_restart();
    int r;
    load_text("the cat sat", "cat");
    @(negedge clock); new_search = 1'b1;
    @(negedge clock); new_search = 1'b0;
    repeat (4) @(negedge clock);
    new_search = 1'b1;
    @(negedge clock); new_search = 1'b0;
    n_cmp++;
    if ({addr, busy, done} !== {TB_ADDR_W'(0), 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL restart_cycle6: got addr=%0d busy=%b done=%b want addr=0 busy=1 done=0",
               addr, busy, done);
    end
    r = 1;
    while (!done && r < BUDGET) begin @(negedge clock); r++; end
    n_cmp++;
    if (r !== 9 || hit !== 1'b1 || hit_addr !== TB_ADDR_W'(4)) begin
      n_err++;
      $display("FAIL restart_result: got done_cycle=%0d hit=%b hit_addr=%0d want 9 1 4",
               r, hit, hit_addr);
    end
  endtask

  // reset clears a held hit and overrides a simultaneous new_search.
  task automatic test_reset_mid();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    n_cmp++;
    if ({addr, CharCount, busy, done, hit, hit_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_in_done: got addr=%0d cc=%0d busy=%b done=%b hit=%b hit_addr=%0d want all 0",
               addr, CharCount, busy, done, hit, hit_addr);
    end
    load_text("the cat sat", "cat");
    @(negedge clock); new_search = 1'b1;
    @(negedge clock); new_search = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1; new_search = 1'b1;
    @(negedge clock); reset = 1'b0; new_search = 1'b0;
    n_cmp++;
    if ({addr, CharCount, busy, done, hit, hit_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_over_new: got addr=%0d cc=%0d busy=%b done=%b want all 0",
               addr, CharCount, busy, done);
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({addr, busy, done} !== '0) begin
      n_err++;
      $display("FAIL idle_stays: got addr=%0d busy=%b done=%b want all 0", addr, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_runaway();
    test_random();
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
